fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the pipelined MIPS core, directly upstream of the decode-stage controller. It owns the fetch PC, drives a wait-state-capable instruction-memory request, and holds the IF/ID pipeline register. It supplies `opD`/`functD` to the controller and accepts the decode-stage redirect (`pcsrcD`, `jumpD`). A one-entry hold buffer and a pending-redirect register absorb decode stalls and slow memory.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stallD` in 1: from the hazard unit; while 1, the IF/ID register holds its value.
- `pcsrcD` in 1: taken conditional branch from the controller; meaningful only when `validD`=1.
- `jumpD` in 1: jump from the controller; meaningful only when `validD`=1.
- `pcbranchD` in 32: branch target computed in decode.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pcF`.
- `imem_rdata` in 32: instruction word; valid in the cycle `imem_ready`=1.
- `imem_ready` in 1: completes the current request in this cycle.
- `instrD` out 32: IF/ID instruction.
- `pcplus4D` out 32: IF/ID PC+4.
- `validD` out 1: 1 when `instrD` is a real instruction, 0 when it is a bubble.
- `opD` out 6: `instrD[31:26]`.
- `functD` out 6: `instrD[5:0]`.

## Operation
- State: `pcF` (32), FSM {FETCH, BUF, DROP}, `bufInstr` (32), `redirPC` (32), IF/ID register {`instrD`, `pcplus4D`, `validD`}.
- `imem_req` = ~`reset` & (state != BUF). `imem_addr` = `pcF`. While `imem_req`=1 and `imem_ready`=0, the address is held stable.
- Define redirect = `validD` & ~`stallD` & (`pcsrcD` | `jumpD`).
- Define target = `jumpD` ? {`pcplus4D[31:28]`, `instrD[25:0]`, 2'b00} : `pcbranchD`. `jumpD` wins if both are asserted.
- Define accept = FETCH & `imem_ready`.
- **FETCH, redirect:**
  - IF/ID loads a bubble (`instrD`=0, `validD`=0).
  - If `imem_ready`=1: discard the data, set `pcF`=target, stay in FETCH.
  - If `imem_ready`=0: set `redirPC`=target, go to DROP.
- **FETCH, accept, ~`stallD`:**
  - IF/ID loads {`imem_rdata`, `pcF`+4, 1}.
  - `pcF` += 4.
- **FETCH, accept, `stallD`:**
  - `bufInstr`=`imem_rdata`, `pcF` += 4, go to BUF.
  - IF/ID holds.
- **FETCH, no accept, ~`stallD`:** IF/ID loads a bubble.
- **BUF:**
  - No request is issued.
  - On redirect: drop the buffer, `pcF`=target, IF/ID bubble, go to FETCH.
  - Else on ~`stallD`: IF/ID loads {`bufInstr`, `pcF`, 1}, go to FETCH.
  - Else: hold.
- **DROP:**
  - `imem_req` stays 1 at the stale address.
  - On `imem_ready`: discard the data, `pcF`=`redirPC`, go to FETCH.
  - `validD` is 0 throughout, so no new redirect can arise.
  - IF/ID loads a bubble if ~`stallD`, otherwise holds.
- **Arithmetic:** all PC arithmetic is modulo 2^32. `pcF` = 32'hFFFF_FFFC + 4 wraps to 0 silently.
- **Reset:** overrides everything in the same edge.
  - Register values: `pcF`=`RESET_PC`, state=FETCH, `instrD`=0, `pcplus4D`=0, `validD`=0, `bufInstr`=0, `redirPC`=0.
  - Outputs during the reset cycle: `imem_req`=0, `opD`=0, `functD`=0.
- **Reset mid-operation:** a request outstanding in FETCH, BUF or DROP is abandoned. Memory must tolerate `imem_req` dropping without `imem_ready`.

## Timing
- Zero-wait memory (`imem_ready` held 1), no stalls: one instruction per cycle.
  - `imem_req` rises in the first cycle after `reset` falls (cycle 0).
  - The instruction at `RESET_PC` is in `instrD` after edge 0.
- Memory wait states: k wait cycles add k bubbles in ID.
- Taken branch or jump in ID at cycle n, zero-wait memory:
  - Edge n: ID bubble, `pcF`=target.
  - Edge n+1: target instruction in ID.
  - Penalty is exactly 1 bubble. There is no delay slot.
- Redirect while a fetch is waiting: the penalty is the remaining wait cycles plus 1 bubble plus the target fetch latency.
- `stallD` and `imem_ready` in the same cycle: the data is captured into BUF with no loss. It is delivered on the first edge with ~`stallD`.
- All outputs are registered or combinational from registers only, except `imem_req`, which also depends on `reset`.

## Test plan
- **Reset and sequential fetch:** `RESET_PC`=32'h0040_0000, `imem_ready`=1, memory word = address.
  - Edge 0 after reset release: `instrD`=32'h0040_0000, `pcplus4D`=32'h0040_0004, `validD`=1.
  - Every following edge: `instrD` increments by 4.
- **Branch redirect:** `instrD` with opcode 6'h04, `pcsrcD`=1, `pcbranchD`=32'h0040_0100.
  - Next edge: `validD`=0, `imem_addr`=32'h0040_0100.
  - Edge after that: `instrD`=32'h0040_0100.
- **Jump:** `pcplus4D`=32'h1000_0008, `instrD[25:0]`=26'h000_0040, `jumpD`=1.
  - Result: `imem_addr`=32'h1000_0100 after one edge.
- **Stall with data arriving:** `stallD`=1 for 3 cycles while `imem_ready`=1 in the first of them.
  - `imem_req`=0 during the remaining stalled cycles.
  - `instrD` is unchanged.
  - After `stallD` falls, `instrD` = the buffered word, `pcplus4D`=`pcF`.
- **Redirect during a wait:** `imem_ready`=0 for 4 cycles; a redirect to 32'h0000_2000 occurs in cycle 1.
  - `imem_addr` stays at the old PC until `imem_ready`.
  - The old data is discarded (never appears with `validD`=1).
  - The next request is to 32'h0000_2000.
- **Reset mid-DROP and PC wrap:**
  - Asserting `reset` in DROP returns `imem_req`=0 and `pcF`=`RESET_PC` on the next edge.
  - Sequential fetch from 32'hFFFF_FFFC is followed by address 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues wait-state-capable
// instruction-memory requests and holds the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [5:0]  opD,
  output logic [5:0]  functD
);

  typedef enum logic [1:0] {FETCH, BUF, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;

  assign redirect = valid_q & ~stallD & (pcsrcD | jumpD);
  assign target   = jumpD ? {pcplus4_q[31:28], instr_q[25:0], 2'b00} : pcbranchD;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    redir_d   = redir_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          instr_d = '0;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = DROP;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (!stallD) begin
            instr_d   = imem_rdata;
            pcplus4_d = pc_q + 32'd4;
            valid_d   = 1'b1;
          end else begin
            buf_d   = imem_rdata;
            state_d = BUF;
          end
        end else if (!stallD) begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
      BUF: begin
        // pc_q already points past the buffered word, so it is that word's PC+4
        if (redirect) begin
          pc_d    = target;
          instr_d = '0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stallD) begin
          instr_d   = buf_q;
          pcplus4_d = pc_q;
          valid_d   = 1'b1;
          state_d   = FETCH;
        end
      end
      DROP: begin
        if (imem_ready) begin
          pc_d    = redir_q;
          state_d = FETCH;
        end
        if (!stallD) begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      buf_q     <= '0;
      redir_q   <= '0;
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      redir_q   <= redir_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req  = ~reset & (state_q != BUF);
  assign imem_addr = pc_q;
  assign instrD    = instr_q;
  assign pcplus4D  = pcplus4_q;
  assign validD    = valid_q;
  assign opD       = instr_q[31:26];
  assign functD    = instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table of per-cycle stimulus and
// expected IF/ID / memory-request values, plus reset-in-DROP and PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD, pcsrcD, jumpD;
  logic [31:0] pcbranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instrD, pcplus4D;
  logic        validD;
  logic [5:0]  opD, functD;

  logic        ovr;
  logic [31:0] ow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // memory returns its own address unless a specific word is forced
  assign imem_rdata = ovr ? ow : imem_addr;

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .pcbranchD(pcbranchD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD), .opD(opD), .functD(functD)
  );

  typedef struct {
    logic        st, br, jp, rdy, ov;
    logic [31:0] tgt, word;
    logic [31:0] e_instr, e_pp4, e_addr;
    logic        e_v, e_req;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic st, br, jp, input logic [31:0] tgt,
                     input logic rdy, ov, input logic [31:0] word,
                     input logic [31:0] e_instr, e_pp4, input logic e_v,
                     input logic [31:0] e_addr, input logic e_req);
    vec_t v;
    v.st = st; v.br = br; v.jp = jp; v.tgt = tgt; v.rdy = rdy; v.ov = ov; v.word = word;
    v.e_instr = e_instr; v.e_pp4 = e_pp4; v.e_v = e_v; v.e_addr = e_addr; v.e_req = e_req;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, br, jp, input logic [31:0] tgt,
                       input logic rdy, ov, input logic [31:0] word);
    stallD = st; pcsrcD = br; jumpD = jp; pcbranchD = tgt;
    imem_ready = rdy; ovr = ov; ow = word;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, '0, 1, 0, '0);

    //   st br jp tgt           rdy ov word            instr          pp4           v  addr          req
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0000, 32'h0040_0004, 1, 32'h0040_0004, 1); // E0
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0004, 32'h0040_0008, 1, 32'h0040_0008, 1);
    add(0, 0, 0, 32'h0,        1, 1, 32'h1080_0005, 32'h1080_0005, 32'h0040_000C, 1, 32'h0040_000C, 1); // beq word
    add(0, 1, 0, 32'h0040_0100, 1, 0, 32'h0,       32'h0,         32'h0040_000C, 0, 32'h0040_0100, 1); // branch
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0100, 32'h0040_0104, 1, 32'h0040_0104, 1);
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0100, 32'h0040_0104, 1, 32'h0040_0108, 0); // stall+data
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0100, 32'h0040_0104, 1, 32'h0040_0108, 0);
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0100, 32'h0040_0104, 1, 32'h0040_0108, 0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0104, 32'h0040_0108, 1, 32'h0040_0108, 1); // buffer out
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_0108, 32'h0040_010C, 1, 32'h0040_010C, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,         32'h0040_010C, 0, 32'h0040_010C, 1); // wait state
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0040_010C, 32'h0040_0110, 1, 32'h0040_0110, 1);
    add(0, 1, 0, 32'h0000_2000, 0, 0, 32'h0,       32'h0,         32'h0040_0110, 0, 32'h0040_0110, 1); // redirect in wait
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,         32'h0040_0110, 0, 32'h0040_0110, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,         32'h0040_0110, 0, 32'h0040_0110, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,         32'h0040_0110, 0, 32'h0040_0110, 1);
    add(0, 0, 0, 32'h0,        1, 1, 32'hDEAD_BEEF, 32'h0,        32'h0040_0110, 0, 32'h0000_2000, 1); // stale dropped
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_2000, 32'h0000_2004, 1, 32'h0000_2004, 1);
    add(0, 1, 0, 32'h1000_0004, 1, 0, 32'h0,       32'h0,         32'h0000_2004, 0, 32'h1000_0004, 1);
    add(0, 0, 0, 32'h0,        1, 1, 32'h0800_0040, 32'h0800_0040, 32'h1000_0008, 1, 32'h1000_0008, 1);
    add(0, 1, 1, 32'h1234_5678, 1, 0, 32'h0,       32'h0,         32'h1000_0008, 0, 32'h1000_0100, 1); // jump wins
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h1000_0100, 32'h1000_0104, 1, 32'h1000_0104, 1);
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h1000_0100, 32'h1000_0104, 1, 32'h1000_0108, 0);
    add(0, 1, 0, 32'h0000_3000, 1, 0, 32'h0,       32'h0,         32'h1000_0104, 0, 32'h0000_3000, 1); // redirect from BUF
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_3000, 32'h0000_3004, 1, 32'h0000_3004, 1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 32'h0000_3004, 1, 32'h0000_3004, 1);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 1, 32'h0000_3008, 1);
    add(1, 1, 0, 32'h0000_9000, 0, 0, 32'h0,       32'h0000_3004, 32'h0000_3008, 1, 32'h0000_3008, 1); // stalled: no redirect
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_3008, 32'h0000_300C, 1, 32'h0000_300C, 1);

    step();
    step();
    check("rst_instrD", instrD, 32'h0);
    check("rst_pcplus4D", pcplus4D, 32'h0);
    check("rst_validD", {31'b0, validD}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_opD", {26'b0, opD}, 32'h0);
    check("rst_functD", {26'b0, functD}, 32'h0);
    check("rst_addr", imem_addr, 32'h0040_0000);
    reset = 1'b0;
    #1;
    check("cycle0_req", {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].st, tv[i].br, tv[i].jp, tv[i].tgt, tv[i].rdy, tv[i].ov, tv[i].word);
      step();
      check($sformatf("v%0d_instrD", i), instrD, tv[i].e_instr);
      check($sformatf("v%0d_pcplus4D", i), pcplus4D, tv[i].e_pp4);
      check($sformatf("v%0d_validD", i), {31'b0, validD}, {31'b0, tv[i].e_v});
      check($sformatf("v%0d_addr", i), imem_addr, tv[i].e_addr);
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
      if (i == 2) begin
        check("opD_beq", {26'b0, opD}, 32'h4);
        check("functD_beq", {26'b0, functD}, 32'h5);
      end
    end

    // enter DROP, then reset while the stale fetch is still outstanding
    drive(0, 1, 0, 32'hFFFF_FFFC, 0, 0, '0);
    step();
    check("drop_addr", imem_addr, 32'h0000_300C);
    drive(0, 0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    #1;
    check("drop_rst_req", {31'b0, imem_req}, 32'h0);
    step();
    check("drop_rst_addr", imem_addr, 32'h0040_0000);
    check("drop_rst_valid", {31'b0, validD}, 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, '0, 1, 0, '0);
    step();
    check("after_rst_instr", instrD, 32'h0040_0000);
    check("after_rst_addr", imem_addr, 32'h0040_0004);

    // PC wrap from the top of the address space
    drive(0, 1, 0, 32'hFFFF_FFFC, 1, 0, '0);
    step();
    check("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, '0, 1, 0, '0);
    step();
    check("wrap_instr", instrD, 32'hFFFF_FFFC);
    check("wrap_pcplus4", pcplus4D, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    step();
    check("wrap_next_pcplus4", pcplus4D, 32'h4);
    check("wrap_next_valid", {31'b0, validD}, 32'h1);
    check("wrap_next_addr", imem_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
